// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one block-wide main-memory port between the I-cache and D-cache
// memory interfaces. One cache is granted at a time. The memory is driven
// from registered copies of the granted request, and mem_ready is routed back
// only to the granted cache. Contention is resolved round-robin. A D-cache
// read that directly follows a completed D-cache write can optionally be
// locked in ahead of the I-cache, which keeps write-back + refill atomic.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   i_mem_read/write/addr/wdata    I-cache request (held until i_mem_ready)
//   i_mem_rdata, i_mem_ready       I-cache response
//   d_mem_read/write/addr/wdata    D-cache request (held until d_mem_ready)
//   d_mem_rdata, d_mem_ready       D-cache response
//   mem_read/write/addr/wdata      registered memory request
//   mem_rdata, mem_ready           memory response
//
// state  | meaning
// IDLE   | no transaction in flight; pick a winner and capture its request
// BUSY_I | I-cache request on the memory port, waiting for mem_ready
// BUSY_D | D-cache request on the memory port, waiting for mem_ready
module mem_port_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 128,
    parameter int LOCK_WB = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_d_q, last_d_d;   // 1 = D-cache had the last grant
    logic                lock_q, lock_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic i_req, d_req, pick_d;

    assign i_req = i_mem_read | i_mem_write;
    assign d_req = d_mem_read | d_mem_write;

    // D wins when alone, when locked after its write-back, or when I had the
    // last turn.
    assign pick_d = d_req & (~i_req | lock_q | ~last_d_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b1;
            lock_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            lock_q      <= lock_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        lock_d      = lock_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                lock_d = 1'b0;
                if (i_req || d_req) begin
                    last_d_d = pick_d;
                    // read+write together is treated as a write
                    if (pick_d) begin
                        state_d     = BUSY_D;
                        mem_write_d = d_mem_write;
                        mem_read_d  = d_mem_read & ~d_mem_write;
                        mem_addr_d  = d_mem_addr;
                        mem_wdata_d = d_mem_wdata;
                    end else begin
                        state_d     = BUSY_I;
                        mem_write_d = i_mem_write;
                        mem_read_d  = i_mem_read & ~i_mem_write;
                        mem_addr_d  = i_mem_addr;
                        mem_wdata_d = i_mem_wdata;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (state_q == BUSY_D && mem_write_q && LOCK_WB != 0)
                        lock_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        i_mem_ready = (state_q == BUSY_I) & mem_ready;
        d_mem_ready = (state_q == BUSY_D) & mem_ready;
    end

    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a table of single-requester transactions plus
// hand-written contention, lock, reset-abort and stray-ready sequences.
// Two instances share all inputs: u_lk (LOCK_WB=1) and u_nl (LOCK_WB=0).
module tb_mem_port_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_mem_read = 0, i_mem_write = 0;
    logic [AW-1:0] i_mem_addr = '0;
    logic [DW-1:0] i_mem_wdata = '0;
    logic          d_mem_read = 0, d_mem_write = 0;
    logic [AW-1:0] d_mem_addr = '0;
    logic [DW-1:0] d_mem_wdata = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 0;

    logic [DW-1:0] i_mem_rdata, d_mem_rdata, nl_i_rdata, nl_d_rdata;
    logic          i_mem_ready, d_mem_ready, nl_i_ready, nl_d_ready;
    logic          mem_read, mem_write, nl_read, nl_write;
    logic [AW-1:0] mem_addr, nl_addr;
    logic [DW-1:0] mem_wdata, nl_wdata;

    int vec_cnt = 0;
    int miss = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_WB(1)) u_lk (
        .clk(clk), .rst_n(rst_n),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
        .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_WB(0)) u_nl (
        .clk(clk), .rst_n(rst_n),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
        .i_mem_rdata(nl_i_rdata), .i_mem_ready(nl_i_ready),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
        .d_mem_rdata(nl_d_rdata), .d_mem_ready(nl_d_ready),
        .mem_read(nl_read), .mem_write(nl_write),
        .mem_addr(nl_addr), .mem_wdata(nl_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    typedef struct {
        string         name;
        bit            who;      // 0 = I-cache, 1 = D-cache
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            lat;
        logic          exp_rd;
        logic          exp_wr;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit who, input logic rd, input logic wr,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (who) begin
            d_mem_read = rd; d_mem_write = wr; d_mem_addr = addr; d_mem_wdata = wdata;
        end else begin
            i_mem_read = rd; i_mem_write = wr; i_mem_addr = addr; i_mem_wdata = wdata;
        end
    endtask

    task automatic clr_req(input bit who);
        if (who) begin
            d_mem_read = 0; d_mem_write = 0;
        end else begin
            i_mem_read = 0; i_mem_write = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        clr_req(0);
        clr_req(1);
        mem_ready = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic do_txn(input vec_t v);
        logic [AW-1:0] held;
        @(negedge clk);
        set_req(v.who, v.rd, v.wr, v.addr, v.wdata);
        @(negedge clk);
        chk({v.name, " mem_read"}, DW'(mem_read), DW'(v.exp_rd));
        chk({v.name, " mem_write"}, DW'(mem_write), DW'(v.exp_wr));
        chk({v.name, " mem_addr"}, DW'(mem_addr), DW'(v.addr));
        if (v.exp_wr) chk({v.name, " mem_wdata"}, mem_wdata, v.wdata);
        held = mem_addr;
        repeat (v.lat - 1) @(negedge clk);
        chk({v.name, " strobe held"}, DW'(mem_read | mem_write), DW'(1));
        mem_rdata = v.rdata;
        mem_ready = 1;
        #1;
        chk({v.name, " granted ready"}, DW'(v.who ? d_mem_ready : i_mem_ready), DW'(1));
        chk({v.name, " other ready"}, DW'(v.who ? i_mem_ready : d_mem_ready), DW'(0));
        if (v.exp_rd) chk({v.name, " rdata"}, v.who ? d_mem_rdata : i_mem_rdata, v.rdata);
        @(negedge clk);
        mem_ready = 0;
        clr_req(v.who);
        #1;
        chk({v.name, " strobes low after"}, DW'({mem_read, mem_write}), DW'(0));
        chk({v.name, " addr kept"}, DW'(mem_addr), DW'(held));
    endtask

    initial begin
        vecs[0] = '{"i_rd_0x10", 0, 1, 0, 28'h0000010, '0,
                    128'h11112222_33334444_55556666_77778888, 4, 1, 0};
        vecs[1] = '{"d_rd_0x20", 1, 1, 0, 28'h0000020, '0,
                    128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 1, 1, 0};
        vecs[2] = '{"d_wr_0x30", 1, 0, 1, 28'h0000030,
                    128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, '0, 2, 0, 1};
        vecs[3] = '{"d_rdwr_0x50", 1, 1, 1, 28'h0000050,
                    128'h01020304_05060708_090A0B0C_0D0E0F10, '0, 3, 0, 1};
        vecs[4] = '{"i_wr_max", 0, 0, 1, 28'hFFFFFFF,
                    128'hFFFFFFFF_00000000_FFFFFFFF_00000000, '0, 1, 0, 1};
        vecs[5] = '{"d_rd_max", 1, 1, 0, 28'hFFFFFFF, '0,
                    128'h80000000_00000000_00000000_00000001, 5, 1, 0};

        // reset values, visible while rst_n is still low
        #1;
        chk("rst mem_read", DW'(mem_read), DW'(0));
        chk("rst mem_write", DW'(mem_write), DW'(0));
        chk("rst mem_addr", DW'(mem_addr), DW'(0));
        chk("rst mem_wdata", mem_wdata, '0);
        chk("rst readies", DW'({i_mem_ready, d_mem_ready}), DW'(0));
        @(negedge clk);
        rst_n = 1;

        for (int k = 0; k < 6; k++) do_txn(vecs[k]);

        // contention: I first after reset, then D, then round-robin favours D
        do_reset();
        @(negedge clk);
        set_req(0, 1, 0, 28'h10, '0);
        set_req(1, 1, 0, 28'h20, '0);
        @(negedge clk);
        chk("rr first grant addr", DW'(mem_addr), DW'(28'h10));
        chk("rr first grant read", DW'(mem_read), DW'(1));
        mem_rdata = 128'h1234;
        mem_ready = 1;
        #1;
        chk("rr i ready", DW'(i_mem_ready), DW'(1));
        chk("rr d ready masked", DW'(d_mem_ready), DW'(0));
        @(negedge clk);
        mem_ready = 0;
        clr_req(0);
        #1;
        chk("rr idle gap", DW'(mem_read), DW'(0));
        @(negedge clk);
        chk("rr d next addr", DW'(mem_addr), DW'(28'h20));
        mem_ready = 1;
        #1;
        chk("rr d ready", DW'(d_mem_ready), DW'(1));
        chk("rr i ready masked", DW'(i_mem_ready), DW'(0));
        @(negedge clk);
        mem_ready = 0;
        clr_req(1);
        do_txn(vecs[0]);
        @(negedge clk);
        set_req(0, 1, 0, 28'h10, '0);
        set_req(1, 1, 0, 28'h20, '0);
        @(negedge clk);
        chk("rr pair2 d first", DW'(mem_addr), DW'(28'h20));
        mem_ready = 1;
        @(negedge clk);
        mem_ready = 0;
        clr_req(1);
        @(negedge clk);
        chk("rr pair2 i second", DW'(mem_addr), DW'(28'h10));
        mem_ready = 1;
        @(negedge clk);
        mem_ready = 0;
        clr_req(0);

        // write-back then refill: lock keeps D ahead of I only with LOCK_WB=1
        do_reset();
        @(negedge clk);
        set_req(1, 0, 1, 28'h30, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        @(negedge clk);
        chk("wb mem_write", DW'(mem_write), DW'(1));
        chk("wb wdata", mem_wdata, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        set_req(0, 1, 0, 28'h10, '0);
        @(negedge clk);
        mem_ready = 1;
        #1;
        chk("wb d ready", DW'(d_mem_ready), DW'(1));
        @(negedge clk);
        mem_ready = 0;
        set_req(1, 1, 0, 28'h40, '0);
        #1;
        chk("wb strobes low", DW'({mem_read, mem_write}), DW'(0));
        @(negedge clk);
        chk("lock d refill addr", DW'(mem_addr), DW'(28'h40));
        chk("lock d refill read", DW'(mem_read), DW'(1));
        chk("nolock i first addr", DW'(nl_addr), DW'(28'h10));
        chk("nolock i first read", DW'(nl_read), DW'(1));

        // reset mid-transaction aborts it
        do_reset();
        @(negedge clk);
        set_req(1, 0, 1, 28'h60, 128'hC0FFEE);
        @(negedge clk);
        chk("abort pre write", DW'(mem_write), DW'(1));
        rst_n = 0;
        mem_ready = 1;
        #1;
        chk("abort write low", DW'(mem_write), DW'(0));
        chk("abort d ready", DW'(d_mem_ready), DW'(0));
        @(negedge clk);
        mem_ready = 0;
        rst_n = 1;
        set_req(0, 1, 0, 28'h11, '0);
        set_req(1, 1, 0, 28'h22, '0);
        @(negedge clk);
        chk("post-abort i first", DW'(mem_addr), DW'(28'h11));

        // stray mem_ready in IDLE is ignored
        do_reset();
        @(negedge clk);
        mem_ready = 1;
        #1;
        chk("stray readies", DW'({i_mem_ready, d_mem_ready}), DW'(0));
        @(negedge clk);
        mem_ready = 0;
        #1;
        chk("stray strobes", DW'({mem_read, mem_write}), DW'(0));
        do_txn(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss);
        $finish;
    end
endmodule
